// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the I/D memory port arbiter.
// State encoding is fixed so it stays stable across users of the package.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEF_AW  = 16;
  localparam int DEF_DW  = 16;
  localparam int DEF_TMO = 15;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// MemReady watchdog: cleared on grant, counts busy cycles without MemReady.
// tc flags the cycle in which the count has reached TMO.
module mem_timeout_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TMO = DEF_TMO
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(TMO));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter onto one memory port.
// Ties alternate on the last grant so neither side waits more than one access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW,
  parameter int TMO = DEF_TMO
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic          IDone,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWdata,
  output logic          DDone,
  output logic [DW-1:0] RData,
  output logic          Err,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  output logic          MemRead,
  output logic          MemWrite,
  input  logic [DW-1:0] MemRdata,
  input  logic          MemReady
);

  state_e        state;
  state_e        state_n;
  logic          last_d;
  logic          we_q;
  logic          err_q;
  logic          busy;
  logic          tc;
  logic          grant_i;
  logic          grant_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (IReq && (!DReq || last_d)) begin
          grant_i = 1'b1;
          state_n = BUSY_I;
        end else if (DReq) begin
          grant_d = 1'b1;
          state_n = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (MemReady || tc) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (grant_i) begin
        addr_q <= IAddr;
        we_q   <= 1'b0;
        last_d <= 1'b0;
      end
      if (grant_d) begin
        addr_q  <= DAddr;
        we_q    <= DWe;
        wdata_q <= DWdata;
        last_d  <= 1'b1;
      end
      // MemReady wins over a timeout landing in the same cycle
      if (busy && MemReady) begin
        rdata_q <= we_q ? '0 : MemRdata;
        err_q   <= 1'b0;
      end else if (busy && tc) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  mem_timeout_counter #(
    .TMO(TMO)
  ) u_tmo (
    .clk   (CLK),
    .rst_n (Reset),
    .clear (grant_i | grant_d),
    .enable(busy & ~MemReady),
    .tc    (tc)
  );

  assign MemAddr  = addr_q;
  assign MemWdata = wdata_q;
  assign MemRead  = busy & ~we_q;
  assign MemWrite = busy & we_q;
  assign IDone    = (state == DONE) & ~last_d;
  assign DDone    = (state == DONE) & last_d;
  assign RData    = rdata_q;
  assign Err      = (state == DONE) & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_mem_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic          IReq = 1'b0;
  logic [AW-1:0] IAddr = '0;
  logic          IDone;
  logic          DReq = 1'b0;
  logic          DWe = 1'b0;
  logic [AW-1:0] DAddr = '0;
  logic [DW-1:0] DWdata = '0;
  logic          DDone;
  logic [DW-1:0] RData;
  logic          Err;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWdata;
  logic          MemRead;
  logic          MemWrite;
  logic [DW-1:0] MemRdata = '0;
  logic          MemReady = 1'b0;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .TMO(TMO)
  ) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .IReq    (IReq),
    .IAddr   (IAddr),
    .IDone   (IDone),
    .DReq    (DReq),
    .DWe     (DWe),
    .DAddr   (DAddr),
    .DWdata  (DWdata),
    .DDone   (DDone),
    .RData   (RData),
    .Err     (Err),
    .MemAddr (MemAddr),
    .MemWdata(MemWdata),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .MemRdata(MemRdata),
    .MemReady(MemReady)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // memory responder: ready after ready_delay busy cycles (-1 = never)
  int ready_delay = 0;
  bit force_ready = 1'b0;
  int bc = 0;

  always @(negedge CLK) begin
    if (MemRead || MemWrite) begin
      MemReady = force_ready || (bc == ready_delay);
      bc++;
    end else begin
      MemReady = force_ready;
      bc = 0;
    end
  end

  // transaction model: who owns the port, how long it has waited
  int            owner = 0;
  bit            in_busy = 1'b0;
  bit            in_done = 1'b0;
  int            age = 0;
  bit            m_last_d = 1'b0;
  bit            m_we = 1'b0;
  bit            m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      owner = 0; in_busy = 0; in_done = 0; age = 0;
      m_last_d = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (in_busy) begin
      if (MemReady) begin
        m_rdata = m_we ? '0 : MemRdata;
        m_err = 0; in_busy = 0; in_done = 1;
      end else if (age == TMO) begin
        m_rdata = '0;
        m_err = 1; in_busy = 0; in_done = 1;
      end else begin
        age++;
      end
    end else if (in_done) begin
      in_done = 0;
      owner = 0;
    end else begin
      if (IReq && DReq) owner = m_last_d ? 1 : 2;
      else if (IReq) owner = 1;
      else if (DReq) owner = 2;
      else owner = 0;
      if (owner != 0) begin
        in_busy = 1;
        age = 0;
        m_last_d = (owner == 2);
        m_addr = (owner == 2) ? DAddr : IAddr;
        m_we = (owner == 2) && DWe;
        if (owner == 2) m_wdata = DWdata;
      end
    end
  end

  always @(negedge CLK) begin
    chk("MemRead", MemRead, in_busy && !m_we);
    chk("MemWrite", MemWrite, in_busy && m_we);
    chk("MemAddr", MemAddr, m_addr);
    chk("MemWdata", MemWdata, m_wdata);
    chk("IDone", IDone, in_done && owner == 1);
    chk("DDone", DDone, in_done && owner == 2);
    chk("Err", Err, in_done ? m_err : 1'b0);
    chk("RData", RData, m_rdata);
  end

  int            kind;
  int            lat;
  int            nrd;
  int            nwr;
  logic [DW-1:0] rd;
  logic          er;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  int            order[4];

  // lat counts cycles from the request cycle through the Done cycle
  task automatic wait_done(input int max, input bit hold);
    kind = 0; lat = 0; nrd = 0; nwr = 0;
    rd = '0; er = 0; wa = '0; wd = '0;
    for (int n = 1; n <= max; n++) begin
      @(negedge CLK);
      if (MemRead) nrd++;
      if (MemWrite) nwr++;
      if (MemRead || MemWrite) begin
        wa = MemAddr;
        wd = MemWdata;
      end
      if (IDone || DDone) begin
        kind = IDone ? 1 : 2;
        lat = n + 1;
        rd = RData;
        er = Err;
        if (!hold) begin
          if (IDone) IReq = 0;
          else DReq = 0;
        end
        return;
      end
    end
    chk("done_wait_expired", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2 Reset = 0;
    IReq = 0;
    DReq = 0;
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #2 Reset = 1;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_memaddr", MemAddr, 16'h0000);
    chk("rst_strobes", {MemRead, MemWrite}, 2'b00);
    chk("rst_done", {IDone, DDone, Err}, 3'b000);
    @(posedge CLK);
    #2 Reset = 1;

    // fetch, zero wait states
    @(negedge CLK);
    ready_delay = 0;
    MemRdata = 16'hA5A5;
    IAddr = 16'h0010;
    IReq = 1;
    wait_done(40, 0);
    chk("s1_kind", kind, 1);
    chk("s1_lat", lat, 3);
    chk("s1_rdata", rd, 16'hA5A5);
    chk("s1_err", er, 0);
    chk("s1_addr", wa, 16'h0010);
    chk("s1_reads", nrd, 1);

    // store
    @(negedge CLK);
    DWe = 1;
    DAddr = 16'h0200;
    DWdata = 16'h1234;
    DReq = 1;
    wait_done(40, 0);
    chk("s2_kind", kind, 2);
    chk("s2_lat", lat, 3);
    chk("s2_nwr", nwr, 1);
    chk("s2_nrd", nrd, 0);
    chk("s2_addr", wa, 16'h0200);
    chk("s2_wdata", wd, 16'h1234);
    chk("s2_err", er, 0);

    // tie after reset: D first, then alternate
    do_reset();
    @(negedge CLK);
    MemRdata = 16'h5555;
    IAddr = 16'h0040;
    DAddr = 16'h0300;
    DWe = 0;
    IReq = 1;
    DReq = 1;
    for (int k = 0; k < 4; k++) begin
      wait_done(40, 1);
      order[k] = kind;
    end
    IReq = 0;
    DReq = 0;
    chk("s3_first", order[0], 2);
    chk("s3_second", order[1], 1);
    chk("s3_third", order[2], 2);
    chk("s3_fourth", order[3], 1);
    chk("s3_last_addr", wa, 16'h0040);

    // timeout with MemReady never raised
    @(negedge CLK);
    ready_delay = -1;
    IAddr = 16'h0080;
    IReq = 1;
    wait_done(60, 0);
    chk("s4_kind", kind, 1);
    chk("s4_err", er, 1);
    chk("s4_rdata", rd, 16'h0000);
    chk("s4_busy", nrd, 16);

    // ready on the terminal cycle beats the timeout
    @(negedge CLK);
    ready_delay = 15;
    MemRdata = 16'hBEEF;
    DWe = 0;
    DAddr = 16'h0444;
    DReq = 1;
    wait_done(60, 0);
    chk("s4b_kind", kind, 2);
    chk("s4b_err", er, 0);
    chk("s4b_rdata", rd, 16'hBEEF);
    chk("s4b_busy", nrd, 16);

    // ready one cycle earlier
    @(negedge CLK);
    ready_delay = 14;
    IAddr = 16'h0090;
    IReq = 1;
    wait_done(60, 0);
    chk("s4c_err", er, 0);
    chk("s4c_busy", nrd, 15);

    // MemReady while idle is ignored
    @(negedge CLK);
    force_ready = 1;
    repeat (4) begin
      @(negedge CLK);
      chk("s5_idle_done", {IDone, DDone}, 2'b00);
    end
    force_ready = 0;

    // reset in the middle of a store
    @(negedge CLK);
    ready_delay = -1;
    DWe = 1;
    DAddr = 16'h0220;
    DWdata = 16'h7777;
    DReq = 1;
    repeat (3) @(negedge CLK);
    chk("s6_busy_wr", MemWrite, 1);
    @(posedge CLK);
    #2 Reset = 0;
    #1;
    chk("s6_drop", {MemRead, MemWrite}, 2'b00);
    chk("s6_addr", MemAddr, 16'h0000);
    DReq = 0;
    repeat (3) begin
      @(negedge CLK);
      chk("s6_no_done", {IDone, DDone}, 2'b00);
    end
    @(posedge CLK);
    #2 Reset = 1;
    @(negedge CLK);
    ready_delay = 0;
    MemRdata = 16'h0F0F;
    IAddr = 16'h0123;
    IReq = 1;
    wait_done(40, 0);
    chk("s6_kind", kind, 1);
    chk("s6_lat", lat, 3);
    chk("s6_rdata", rd, 16'h0F0F);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
